pc_next_unit: RTL and testbench
===============================

Name: pc_next_unit

Overview:
- Program-counter stage for the RV32I core; owns the PC register and the instruction-fetch request.
- Consumes the sign-extended immediate produced by the immediate extender.
- Computes next PC for sequential, branch, JAL and JALR flow; handles fetch wait-states and pipeline stall.
- Sits between the decode/immediate path and the instruction memory port.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TRAP_VEC, 32'h0000_0100, target used on misaligned transfer (optional feature only).

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- stall  in  1  hazard/back-pressure; blocks PC advance.
- if_ready  in  1  imem has returned instruction for pc_out this cycle.
- npc_op  in  2  next-PC select from control unit.
- br_taken  in  1  branch condition result from ALU compare.
- immout  in  32  extended immediate; B/J offsets already have bit0=0.
- rs1_data  in  32  register rs1 value for JALR.
- pc_out  out  32  current PC / fetch address.
- pc_plus4  out  32  pc_out+4, for JAL/JALR link writeback.
- if_req  out  1  fetch request to imem.
- redirect  out  1  one-cycle pulse when a taken transfer commits.
- misalign_trap  out  1  one-cycle pulse (feature only, else tied 0).

Behaviour:
- Reset: pc_out=RESET_PC, if_req=0, redirect=0, misalign_trap=0, pend_pc=0, state=S_BOOT.
- npc_op encoding: 0 PLUS4, 1 BRANCH, 2 JAL, 3 JALR.
- Target (combinational, 32-bit, wrap modulo 2^32, no overflow flag):
  - PLUS4: pc_out+4.
  - BRANCH: br_taken ? pc_out+immout : pc_out+4.
  - JAL: pc_out+immout.
  - JALR: (rs1_data+immout) with bit0 cleared.
- taken = (npc_op==JAL) | (npc_op==JALR) | (npc_op==BRANCH & br_taken).
- FSM states:
  - S_BOOT: if_req=0; next cycle goes to S_FETCH. Guarantees one idle cycle after reset release.
  - S_FETCH: if_req=1.
    - if_ready & ~stall: pc_out<=target; redirect<=taken; stay in S_FETCH.
    - if_ready & stall: pend_pc<=target, pend_taken<=taken; go to S_HOLD; pc_out unchanged.
    - ~if_ready: hold pc_out and if_req; ignore npc_op/immout/br_taken.
  - S_HOLD: if_req=0; immout and other inputs ignored.
    - ~stall: pc_out<=pend_pc; redirect<=pend_taken; go to S_FETCH.
    - stall remains high: stay in S_HOLD indefinitely.
- Latency:
  - PC update visible one cycle after the accepting edge.
  - Redirect pulse is coincident with the new pc_out and lasts exactly 1 cycle.
- Boundary cases:
  - PC 32'hFFFF_FFFC + 4 wraps to 0.
  - stall and if_ready rising in the same cycle: stall wins (capture to pend_pc).
  - Reset mid-S_HOLD discards pend_pc.
  - npc_op values outside 0..3 cannot occur (2-bit field).
- pc_plus4 is always pc_out+4, combinational; valid in every state.

Optional Feature:
- Macro: PC_MISALIGN_TRAP_EN.
- Defined:
  - If taken and target[1]==1 at commit, pc_out<=TRAP_VEC instead of target.
  - misalign_trap pulses 1 cycle, redirect pulses as well.
  - Applies equally to the S_HOLD release path; latch the trap flag alongside pend_pc.
- Undefined: target committed unmodified; misalign_trap constant 0.

Decomposition:
- Shared definitions header (alongside existing control encodings):
  - NPC_PLUS4, NPC_BRANCH, NPC_JAL, NPC_JALR (2-bit).
  - State encodings S_BOOT, S_FETCH, S_HOLD.
- One natural sub-module: npc_calc (pure combinational target/taken computation). FSM and registers stay in pc_next_unit.

Test Plan:
- Reset release with RESET_PC=0: if_req=0 for 1 cycle, then 1. With if_ready=1 and npc_op=PLUS4 for 3 cycles: pc_out 0→4→8→C, redirect never high.
- pc=0x40, npc_op=BRANCH, immout=0xFFFF_FFF8, br_taken=1, if_ready=1: next pc_out=0x38, redirect=1 for one cycle. Same stimulus with br_taken=0 gives 0x44, redirect=0.
- pc=0x100, npc_op=JALR, rs1_data=0x2001, immout=0x4: next pc_out=0x2004 (bit0 cleared); pc_plus4=0x104 before the edge.
- pc=0x20, npc_op=JAL, immout=0x80, if_ready=1, stall=1 for 3 cycles:
  - pc_out holds 0x20; if_req=0 during S_HOLD.
  - After stall drops: pc_out=0xA0, redirect pulse.
  - Changing immout during the hold has no effect.
- pc=0xFFFF_FFFC, PLUS4: pc_out=0. Assert rst asynchronously mid-S_HOLD: pc_out=RESET_PC immediately, if_req=0.
- With PC_MISALIGN_TRAP_EN, pc=0x10, JAL, immout=0x6: pc_out=TRAP_VEC, misalign_trap=1 for one cycle. Without the macro: pc_out=0x16, misalign_trap=0.

Source files
------------

// File: rtl/pc_next_unit_pkg.sv
// Shared encodings for the PC stage: next-PC select codes, FSM state
// codes and the result bundle of the target calculator.
package pc_next_unit_pkg;

  // Next-PC select from the control unit
  localparam logic [1:0] NPC_PLUS4  = 2'd0;
  localparam logic [1:0] NPC_BRANCH = 2'd1;
  localparam logic [1:0] NPC_JAL    = 2'd2;
  localparam logic [1:0] NPC_JALR   = 2'd3;

  // PC stage FSM states
  localparam logic [1:0] S_BOOT  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  typedef struct packed {
    logic [31:0] target;
    logic        taken;
  } npc_res_t;

endpackage

// File: rtl/pc_next_unit_if.sv
// Fetch/control bundle between the PC stage, the control path and imem.
// master: the PC stage itself; slave: the surrounding core / memory.
interface pc_next_unit_if;
  logic        stall;
  logic        if_ready;
  logic [1:0]  npc_op;
  logic        br_taken;
  logic [31:0] immout;
  logic [31:0] rs1_data;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        if_req;
  logic        redirect;
  logic        misalign_trap;

  modport master (
    input  stall, if_ready, npc_op, br_taken, immout, rs1_data,
    output pc_out, pc_plus4, if_req, redirect, misalign_trap
  );

  modport slave (
    output stall, if_ready, npc_op, br_taken, immout, rs1_data,
    input  pc_out, pc_plus4, if_req, redirect, misalign_trap
  );
endinterface

// File: rtl/pc_next_unit_npc_calc.sv
// Pure combinational next-PC target and taken computation.
// All sums wrap modulo 2^32.
module pc_next_unit_npc_calc
  import pc_next_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  npc_op,
  input  logic        br_taken,
  input  logic [31:0] immout,
  input  logic [31:0] rs1_data,
  output npc_res_t    res
);

  logic [31:0] pc_inc;
  logic [31:0] pc_rel;
  logic [31:0] jalr_sum;

  // Select target and taken flag from the control encoding
  always_comb begin
    pc_inc     = pc + 32'd4;
    pc_rel     = pc + immout;
    jalr_sum   = rs1_data + immout;
    res.target = pc_inc;
    res.taken  = 1'b0;
    case (npc_op)
      NPC_PLUS4: begin
        res.target = pc_inc;
        res.taken  = 1'b0;
      end
      NPC_BRANCH: begin
        res.target = br_taken ? pc_rel : pc_inc;
        res.taken  = br_taken;
      end
      NPC_JAL: begin
        res.target = pc_rel;
        res.taken  = 1'b1;
      end
      default: begin
        res.target = {jalr_sum[31:1], 1'b0};
        res.taken  = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/pc_next_unit.sv
// PC register and instruction-fetch request for the RV32I core.
// Optional macro PC_MISALIGN_TRAP_EN: a taken transfer whose target has
// bit1 set commits TRAP_VEC instead and pulses misalign_trap.
//
// state   | meaning
// S_BOOT  | one idle cycle after reset, no fetch request
// S_FETCH | fetch pc_out, commit next PC when imem answers
// S_HOLD  | stalled with a captured next PC, no fetch request
module pc_next_unit
  import pc_next_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC = 32'h0000_0100
) (
  input logic            clk,
  input logic            rst,
  pc_next_unit_if.master bus
);

`ifdef PC_MISALIGN_TRAP_EN
  localparam logic TRAP_EN = 1'b1;
`else
  localparam logic TRAP_EN = 1'b0;
`endif

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        pend_taken_q, pend_taken_d;
  logic        pend_trap_q, pend_trap_d;
  logic        redirect_q, redirect_d;
  logic        trap_q, trap_d;
  npc_res_t    res;
  logic        misalign;

  pc_next_unit_npc_calc u_npc_calc (
    .pc       (pc_q),
    .npc_op   (bus.npc_op),
    .br_taken (bus.br_taken),
    .immout   (bus.immout),
    .rs1_data (bus.rs1_data),
    .res      (res)
  );

  // Constant 0 when the trap feature is compiled out
  assign misalign = TRAP_EN & res.taken & res.target[1];

  // Next-state and next-PC decision
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_pc_d    = pend_pc_q;
    pend_taken_d = pend_taken_q;
    pend_trap_d  = pend_trap_q;
    redirect_d   = 1'b0;
    trap_d       = 1'b0;
    case (state_q)
      S_BOOT: state_d = S_FETCH;
      S_FETCH: begin
        if (bus.if_ready) begin
          if (bus.stall) begin
            // stall wins over a same-cycle if_ready: park the target
            pend_pc_d    = res.target;
            pend_taken_d = res.taken;
            pend_trap_d  = misalign;
            state_d      = S_HOLD;
          end else begin
            pc_d       = misalign ? TRAP_VEC : res.target;
            redirect_d = res.taken;
            trap_d     = misalign;
          end
        end
      end
      S_HOLD: begin
        if (!bus.stall) begin
          pc_d       = pend_trap_q ? TRAP_VEC : pend_pc_q;
          redirect_d = pend_taken_q;
          trap_d     = pend_trap_q;
          state_d    = S_FETCH;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  // State and PC registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_BOOT;
      pc_q         <= RESET_PC;
      pend_pc_q    <= 32'h0;
      pend_taken_q <= 1'b0;
      pend_trap_q  <= 1'b0;
      redirect_q   <= 1'b0;
      trap_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_pc_q    <= pend_pc_d;
      pend_taken_q <= pend_taken_d;
      pend_trap_q  <= pend_trap_d;
      redirect_q   <= redirect_d;
      trap_q       <= trap_d;
    end
  end

  assign bus.pc_out        = pc_q;
  assign bus.pc_plus4      = pc_q + 32'd4;
  assign bus.if_req        = (state_q == S_FETCH);
  assign bus.redirect      = redirect_q;
  assign bus.misalign_trap = trap_q;

endmodule

// File: tb/tb_pc_next_unit.sv
// Self-checking bench for pc_next_unit: directed table, hand-written
// stall/reset/trap sequences and a randomized run against a reference model.
module tb_pc_next_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] TVEC   = 32'h0000_0100;
`ifdef PC_MISALIGN_TRAP_EN
  localparam bit TB_TRAP = 1'b1;
`else
  localparam bit TB_TRAP = 1'b0;
`endif

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  pc_next_unit_if bus ();

  pc_next_unit #(.RESET_PC(RST_PC), .TRAP_VEC(TVEC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic        br;
    logic [31:0] imm;
    logic [31:0] rs1;
    logic        stall;
    logic        ready;
    logic [31:0] pc;
    logic        redir;
    logic        ifreq;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] op, input logic br, input logic [31:0] imm,
                       input logic [31:0] rs1, input logic stall, input logic ready);
    bus.npc_op   = op;
    bus.br_taken = br;
    bus.immout   = imm;
    bus.rs1_data = rs1;
    bus.stall    = stall;
    bus.if_ready = ready;
  endtask

  // Reference: next PC computed straight from the instruction semantics
  function automatic logic [31:0] ref_target(input logic [1:0] op, input logic br,
      input logic [31:0] imm, input logic [31:0] rs1, input logic [31:0] pc);
    logic [31:0] t;
    case (op)
      2'd0: t = pc + 32'd4;
      2'd1: t = br ? pc + imm : pc + 32'd4;
      2'd2: t = pc + imm;
      default: begin
        t = rs1 + imm;
        t = t & 32'hFFFF_FFFE;
      end
    endcase
    return t;
  endfunction

  function automatic logic ref_taken(input logic [1:0] op, input logic br);
    return (op == 2'd2) || (op == 2'd3) || (op == 2'd1 && br);
  endfunction

  // Model state for the random phase
  logic [31:0] m_pc, m_pend;
  logic        m_hold, m_pend_taken, m_pend_trap, m_redir, m_trap;

  initial begin
    logic [31:0] t;
    logic        tk, tr;
    n_vec = 0;
    n_err = 0;

    //            op    br    imm            rs1            st    rdy   pc             redir ifreq
    tbl[0]  = '{2'd2, 1'b0, 32'h0000_0034, 32'h0,         1'b0, 1'b1, 32'h0000_0040, 1'b1, 1'b1};
    tbl[1]  = '{2'd1, 1'b1, 32'hFFFF_FFF8, 32'h0,         1'b0, 1'b1, 32'h0000_0038, 1'b1, 1'b1};
    tbl[2]  = '{2'd2, 1'b0, 32'h0000_0008, 32'h0,         1'b0, 1'b1, 32'h0000_0040, 1'b1, 1'b1};
    tbl[3]  = '{2'd1, 1'b0, 32'hFFFF_FFF8, 32'h0,         1'b0, 1'b1, 32'h0000_0044, 1'b0, 1'b1};
    tbl[4]  = '{2'd2, 1'b0, 32'h0000_00BC, 32'h0,         1'b0, 1'b1, 32'h0000_0100, 1'b1, 1'b1};
    tbl[5]  = '{2'd3, 1'b0, 32'h0000_0004, 32'h0000_2001, 1'b0, 1'b1, 32'h0000_2004, 1'b1, 1'b1};
    tbl[6]  = '{2'd2, 1'b0, 32'h0000_1000, 32'h0,         1'b0, 1'b0, 32'h0000_2004, 1'b0, 1'b1};
    tbl[7]  = '{2'd3, 1'b1, 32'h0000_0009, 32'hFFFF_FFF0, 1'b0, 1'b1, 32'hFFFF_FFF8, 1'b1, 1'b1};
    tbl[8]  = '{2'd0, 1'b1, 32'h0000_0050, 32'h0,         1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1};
    tbl[9]  = '{2'd0, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 1'b1, 32'h0000_0000, 1'b0, 1'b1};
    tbl[10] = '{2'd1, 1'b1, 32'h0000_0020, 32'h0,         1'b0, 1'b1, 32'h0000_0020, 1'b1, 1'b1};

    // Reset and boot idle cycle
    rst = 1'b1;
    drive(2'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
    step();
    step();
    chk("rst_pc", bus.pc_out, RST_PC);
    chk("rst_ifreq", bus.if_req, 0);
    chk("rst_redir", bus.redirect, 0);
    chk("rst_trap", bus.misalign_trap, 0);
    rst = 1'b0;
    chk("boot_ifreq", bus.if_req, 0);
    step();
    chk("fetch_ifreq", bus.if_req, 1);
    chk("fetch_pc0", bus.pc_out, 32'h0);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("seq_pc", bus.pc_out, 32'(i * 4));
      chk("seq_redir", bus.redirect, 0);
    end

    // Directed table
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].op, tbl[i].br, tbl[i].imm, tbl[i].rs1, tbl[i].stall, tbl[i].ready);
      step();
      chk("tbl_pc", bus.pc_out, tbl[i].pc);
      chk("tbl_pc4", bus.pc_plus4, tbl[i].pc + 32'd4);
      chk("tbl_redir", bus.redirect, tbl[i].redir);
      chk("tbl_ifreq", bus.if_req, tbl[i].ifreq);
      chk("tbl_trap", bus.misalign_trap, 0);
    end

    // Stall with JAL pending, immediate changes during the hold
    drive(2'd2, 1'b0, 32'h0000_0080, 32'h0, 1'b1, 1'b1);
    step();
    chk("hold_pc", bus.pc_out, 32'h20);
    chk("hold_ifreq", bus.if_req, 0);
    chk("hold_redir", bus.redirect, 0);
    drive(2'd0, 1'b1, 32'h0000_0999, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("hold2_pc", bus.pc_out, 32'h20);
      chk("hold2_ifreq", bus.if_req, 0);
    end
    drive(2'd0, 1'b0, 32'h0001_2345, 32'h0, 1'b0, 1'b1);
    step();
    chk("rel_pc", bus.pc_out, 32'hA0);
    chk("rel_redir", bus.redirect, 1);
    chk("rel_ifreq", bus.if_req, 1);
    drive(2'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    chk("rel_pulse_end", bus.redirect, 0);
    chk("rel_pc_hold", bus.pc_out, 32'hA0);

    // Misaligned JAL target
    drive(2'd2, 1'b0, 32'hFFFF_FF70, 32'h0, 1'b0, 1'b1);
    step();
    chk("to10_pc", bus.pc_out, 32'h10);
    drive(2'd2, 1'b0, 32'h0000_0006, 32'h0, 1'b0, 1'b1);
    step();
    chk("mis_pc", bus.pc_out, TB_TRAP ? TVEC : 32'h16);
    chk("mis_trap", bus.misalign_trap, TB_TRAP ? 1 : 0);
    chk("mis_redir", bus.redirect, 1);
    drive(2'd0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    step();
    chk("mis_trap_end", bus.misalign_trap, 0);
    chk("mis_redir_end", bus.redirect, 0);

    // Asynchronous reset in the middle of a hold discards the pending PC
    drive(2'd2, 1'b0, 32'h0000_0040, 32'h0, 1'b1, 1'b1);
    step();
    chk("rh_ifreq", bus.if_req, 0);
    drive(2'd0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    #3 rst = 1'b1;
    #1;
    chk("rh_async_pc", bus.pc_out, RST_PC);
    chk("rh_async_ifreq", bus.if_req, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.stall = 1'b0;
    chk("rh_boot_ifreq", bus.if_req, 0);
    step();
    chk("rh_fetch_ifreq", bus.if_req, 1);
    chk("rh_fetch_pc", bus.pc_out, RST_PC);
    step();
    chk("rh_no_pend_pc", bus.pc_out, RST_PC);
    chk("rh_no_pend_redir", bus.redirect, 0);

    // Randomized run against the model, starting in fetch at RESET_PC
    m_pc = RST_PC;
    m_hold = 1'b0;
    m_pend = 32'h0;
    m_pend_taken = 1'b0;
    m_pend_trap = 1'b0;
    for (int n = 0; n < 600; n++) begin
      logic [31:0] imm;
      imm = $urandom;
      if ($urandom_range(0, 3) != 0) imm = imm & 32'h0000_0FFC;
      if ($urandom_range(0, 7) == 0) imm = imm | 32'h2;
      imm = imm & 32'hFFFF_FFFE;
      drive(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), imm, $urandom,
            ($urandom_range(0, 9) < 3), ($urandom_range(0, 9) < 7));
      m_redir = 1'b0;
      m_trap  = 1'b0;
      t  = ref_target(bus.npc_op, bus.br_taken, bus.immout, bus.rs1_data, m_pc);
      tk = ref_taken(bus.npc_op, bus.br_taken);
      tr = TB_TRAP && tk && t[1];
      if (m_hold) begin
        if (!bus.stall) begin
          m_pc    = m_pend_trap ? TVEC : m_pend;
          m_redir = m_pend_taken;
          m_trap  = m_pend_trap;
          m_hold  = 1'b0;
        end
      end else if (bus.if_ready && bus.stall) begin
        m_pend       = t;
        m_pend_taken = tk;
        m_pend_trap  = tr;
        m_hold       = 1'b1;
      end else if (bus.if_ready) begin
        m_pc    = tr ? TVEC : t;
        m_redir = tk;
        m_trap  = tr;
      end
      step();
      chk("rnd_pc", bus.pc_out, m_pc);
      chk("rnd_pc4", bus.pc_plus4, m_pc + 32'd4);
      chk("rnd_redir", bus.redirect, m_redir);
      chk("rnd_ifreq", bus.if_req, !m_hold);
      chk("rnd_trap", bus.misalign_trap, m_trap);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
